// File: rtl/rf_port_arbiter_if.sv
// Command/response bundle between three requesters and the shared register-file arbiter.
interface rf_port_arbiter_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = 4
) ();
  logic [2:0]         req_valid;
  logic [2:0]         req_we;
  logic [3*AW-1:0]    req_addr;
  logic [3*WIDTH-1:0] req_wdata;
  logic [2:0]         req_ready;
  logic               rsp_valid;
  logic [1:0]         rsp_id;
  logic [WIDTH-1:0]   rsp_data;
  logic               rsp_err;

  // Client side drives commands and observes grants/responses.
  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );
endinterface

// File: rtl/rf_port_arbiter.sv
// Round-robin sharing of a 1W/1R register file among three requesters.
// Independent write and read arbiters; read data returns one cycle after grant.
module rf_port_arbiter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 10,
  parameter int unsigned AW    = 4
) (
  input logic             clk,
  input logic             reset,
  rf_port_arbiter_if.slave bus
);

  localparam int unsigned AWP1 = AW + 1;

  // Returns {granted, index} for the first eligible requester from ptr onward, mod 3.
  function automatic logic [2:0] rr_pick(input logic [1:0] ptr, input logic [2:0] elig);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    idx = ptr;
    for (int unsigned k = 0; k < 3; k++) begin
      if (!res[2] && elig[idx]) res = {1'b1, idx};
      idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    end
    return res;
  endfunction

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [1:0]       wr_ptr_q, wr_ptr_d;
  logic [1:0]       rd_ptr_q, rd_ptr_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [1:0]       rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;

  logic [AW-1:0]    addr_a  [3];
  logic [WIDTH-1:0] wdata_a [3];
  logic [2:0]       wr_pick, rd_pick;
  logic             wr_gnt, rd_gnt;
  logic [1:0]       wr_idx, rd_idx;
  logic [AW-1:0]    wr_addr, rd_addr;
  logic             wr_in_range, rd_in_range;
  logic             mem_we;
  logic [2:0]       ready;

  // Unpack per-requester address and write data lanes.
  always_comb begin
    for (int unsigned i = 0; i < 3; i++) begin
      addr_a[i]  = bus.req_addr[i*AW +: AW];
      wdata_a[i] = bus.req_wdata[i*WIDTH +: WIDTH];
    end
  end

  // Arbitration, grants and next-state of pointers and response registers.
  always_comb begin
    wr_pick = rr_pick(wr_ptr_q, bus.req_valid & bus.req_we);
    rd_pick = rr_pick(rd_ptr_q, bus.req_valid & ~bus.req_we);
    wr_gnt  = wr_pick[2] & ~reset;
    rd_gnt  = rd_pick[2] & ~reset;
    wr_idx  = wr_pick[1:0];
    rd_idx  = rd_pick[1:0];

    ready = 3'b000;
    if (wr_gnt) ready[wr_idx] = 1'b1;
    if (rd_gnt) ready[rd_idx] = 1'b1;

    wr_addr     = addr_a[wr_idx];
    rd_addr     = addr_a[rd_idx];
    // Extra bit keeps the bound correct when DEPTH == 2**AW.
    wr_in_range = ({1'b0, wr_addr} < AWP1'(DEPTH));
    rd_in_range = ({1'b0, rd_addr} < AWP1'(DEPTH));
    mem_we      = wr_gnt & wr_in_range;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_gnt) wr_ptr_d = (wr_idx == 2'd2) ? 2'd0 : wr_idx + 2'd1;
    if (rd_gnt) rd_ptr_d = (rd_idx == 2'd2) ? 2'd0 : rd_idx + 2'd1;

    rsp_valid_d = rd_gnt;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    if (rd_gnt) begin
      rsp_id_d   = rd_idx;
      rsp_data_d = rd_in_range ? mem_q[rd_addr] : '0;
      rsp_err_d  = ~rd_in_range;
    end
  end

  // Pointer and response registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= 2'd0;
      rd_ptr_q    <= 2'd0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 2'd0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Storage array; contents survive reset, out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_addr] <= wdata_a[wr_idx];
  end

  assign bus.req_ready = ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_rf_port_arbiter.sv
// Directed vector bench for rf_port_arbiter (WIDTH=8, DEPTH=10, AW=4).
module tb_rf_port_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  rf_port_arbiter_if #(.WIDTH(8), .AW(4)) bus ();

  rf_port_arbiter #(.WIDTH(8), .DEPTH(10), .AW(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [2:0]  valid;
    logic [2:0]  we;
    logic [11:0] addr;   // {a2, a1, a0}
    logic [23:0] wdata;  // {d2, d1, d0}
    logic [2:0]  exp_ready;
    logic        exp_rv;
    logic [1:0]  exp_id;
    logic [7:0]  exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs [$];

  function automatic vec_t mk(logic rst, logic [2:0] valid, logic [2:0] we,
                              logic [3:0] a2, logic [3:0] a1, logic [3:0] a0,
                              logic [7:0] d2, logic [7:0] d1, logic [7:0] d0,
                              logic [2:0] rdy, logic rv, logic [1:0] id,
                              logic [7:0] data, logic err);
    vec_t v;
    v.rst = rst; v.valid = valid; v.we = we;
    v.addr = {a2, a1, a0}; v.wdata = {d2, d1, d0};
    v.exp_ready = rdy; v.exp_rv = rv; v.exp_id = id; v.exp_data = data; v.exp_err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic [2:0] valid, input logic [2:0] we,
                       input logic [11:0] addr, input logic [23:0] wdata);
    reset         = rst;
    bus.req_valid = valid;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
  endtask

  task automatic chk_rsp(input string tag, input logic rv, input logic [1:0] id,
                         input logic [7:0] data, input logic err);
    chk({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'(rv));
    chk({tag, ".rsp_id"},    32'(bus.rsp_id),    32'(id));
    chk({tag, ".rsp_data"},  32'(bus.rsp_data),  32'(data));
    chk({tag, ".rsp_err"},   32'(bus.rsp_err),   32'(err));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset, then basic write/read.
    vecs.push_back(mk(1, 3'b111, 3'b000, 0, 0, 0, 0, 0, 0,       3'b000, 0, 0, 8'h00, 0));
    vecs.push_back(mk(1, 3'b111, 3'b000, 0, 0, 0, 0, 0, 0,       3'b000, 0, 0, 8'h00, 0));
    vecs.push_back(mk(0, 3'b001, 3'b001, 0, 0, 5, 0, 0, 8'hA5,   3'b001, 0, 0, 8'h00, 0));
    vecs.push_back(mk(0, 3'b010, 3'b000, 0, 5, 0, 0, 0, 0,       3'b010, 1, 1, 8'hA5, 0));
    // Prefill 0..2, hold check on response fields.
    vecs.push_back(mk(0, 3'b001, 3'b001, 0, 0, 0, 0, 0, 8'h10,   3'b001, 0, 1, 8'hA5, 0));
    vecs.push_back(mk(0, 3'b010, 3'b010, 0, 1, 0, 0, 8'h21, 0,   3'b010, 0, 1, 8'hA5, 0));
    vecs.push_back(mk(0, 3'b100, 3'b100, 2, 0, 0, 8'h32, 0, 0,   3'b100, 0, 1, 8'hA5, 0));
    vecs.push_back(mk(0, 3'b100, 3'b000, 5, 0, 0, 0, 0, 0,       3'b100, 1, 2, 8'hA5, 0));
    // Round-robin continuous reads.
    vecs.push_back(mk(0, 3'b111, 3'b000, 2, 1, 0, 0, 0, 0,       3'b001, 1, 0, 8'h10, 0));
    vecs.push_back(mk(0, 3'b111, 3'b000, 2, 1, 0, 0, 0, 0,       3'b010, 1, 1, 8'h21, 0));
    vecs.push_back(mk(0, 3'b111, 3'b000, 2, 1, 0, 0, 0, 0,       3'b100, 1, 2, 8'h32, 0));
    vecs.push_back(mk(0, 3'b111, 3'b000, 2, 1, 0, 0, 0, 0,       3'b001, 1, 0, 8'h10, 0));
    vecs.push_back(mk(0, 3'b111, 3'b000, 2, 1, 0, 0, 0, 0,       3'b010, 1, 1, 8'h21, 0));
    vecs.push_back(mk(0, 3'b111, 3'b000, 2, 1, 0, 0, 0, 0,       3'b100, 1, 2, 8'h32, 0));
    // Concurrent write and read of addr 3: read-before-write, then visibility.
    vecs.push_back(mk(0, 3'b001, 3'b001, 0, 0, 3, 0, 0, 8'h11,   3'b001, 0, 2, 8'h32, 0));
    vecs.push_back(mk(0, 3'b101, 3'b001, 3, 0, 3, 0, 0, 8'h22,   3'b101, 1, 2, 8'h11, 0));
    vecs.push_back(mk(0, 3'b010, 3'b000, 0, 3, 0, 0, 0, 0,       3'b010, 1, 1, 8'h22, 0));
    // Bounds: last valid word, out-of-range write and read, no aliasing.
    vecs.push_back(mk(0, 3'b010, 3'b010, 0, 9, 0, 0, 8'h3C, 0,   3'b010, 0, 1, 8'h22, 0));
    vecs.push_back(mk(0, 3'b001, 3'b000, 0, 0, 9, 0, 0, 0,       3'b001, 1, 0, 8'h3C, 0));
    vecs.push_back(mk(0, 3'b100, 3'b100, 12, 0, 0, 8'hFF, 0, 0,  3'b100, 0, 0, 8'h3C, 0));
    vecs.push_back(mk(0, 3'b100, 3'b000, 12, 0, 0, 0, 0, 0,      3'b100, 1, 2, 8'h00, 1));
    vecs.push_back(mk(0, 3'b001, 3'b000, 0, 0, 9, 0, 0, 0,       3'b001, 1, 0, 8'h3C, 0));
    vecs.push_back(mk(0, 3'b010, 3'b000, 0, 2, 0, 0, 0, 0,       3'b010, 1, 1, 8'h32, 0));
    // Three contending writers (all dropped, out of range).
    vecs.push_back(mk(0, 3'b111, 3'b111, 15, 14, 13, 1, 2, 3,   3'b001, 0, 1, 8'h32, 0));
    vecs.push_back(mk(0, 3'b111, 3'b111, 15, 14, 13, 1, 2, 3,   3'b010, 0, 1, 8'h32, 0));
    vecs.push_back(mk(0, 3'b111, 3'b111, 15, 14, 13, 1, 2, 3,   3'b100, 0, 1, 8'h32, 0));

    drive(1'b1, 3'b000, 3'b000, '0, '0);
    @(posedge clk); #1;

    foreach (vecs[n]) begin
      drive(vecs[n].rst, vecs[n].valid, vecs[n].we, vecs[n].addr, vecs[n].wdata);
      #2;
      chk($sformatf("v%0d.req_ready", n), 32'(bus.req_ready), 32'(vecs[n].exp_ready));
      @(posedge clk); #1;
      chk_rsp($sformatf("v%0d", n), vecs[n].exp_rv, vecs[n].exp_id,
              vecs[n].exp_data, vecs[n].exp_err);
    end

    // Reset mid-operation: rd_ptr is 2 here; req1 granted, reset lands on the edge.
    drive(1'b0, 3'b010, 3'b000, {4'd0, 4'd0, 4'd0}, '0);
    #2;
    chk("midrst.grant", 32'(bus.req_ready), 32'(3'b010));
    #1 reset = 1'b1;
    @(posedge clk); #1;
    chk_rsp("midrst.edge", 1'b0, 2'd0, 8'h00, 1'b0);

    drive(1'b1, 3'b111, 3'b000, {4'd5, 4'd3, 4'd9}, '0);
    #2;
    chk("midrst.hold_ready", 32'(bus.req_ready), 32'(3'b000));
    @(posedge clk); #1;
    chk_rsp("midrst.hold", 1'b0, 2'd0, 8'h00, 1'b0);

    // After reset rd_ptr restarts at 0; memory contents retained.
    reset = 1'b0;
    #2;
    chk("post.g0", 32'(bus.req_ready), 32'(3'b001));
    @(posedge clk); #1;
    chk_rsp("post.r0", 1'b1, 2'd0, 8'h3C, 1'b0);
    #2;
    chk("post.g1", 32'(bus.req_ready), 32'(3'b010));
    @(posedge clk); #1;
    chk_rsp("post.r1", 1'b1, 2'd1, 8'h22, 1'b0);
    #2;
    chk("post.g2", 32'(bus.req_ready), 32'(3'b100));
    @(posedge clk); #1;
    chk_rsp("post.r2", 1'b1, 2'd2, 8'hA5, 1'b0);

    drive(1'b0, 3'b000, 3'b000, '0, '0);
    @(posedge clk); #1;
    chk("idle.rsp_valid", 32'(bus.rsp_valid), 32'(1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
